reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 16-entry in-order reorder buffer (ROB).
- Consumes the completion flag and completion index that the MEM/WB pipeline register delivers, together with the writeback result.
- Issue allocates entries in program order; writeback marks them complete out of order; the head entry retires one per cycle to the register file.
- Sits between decode/issue, the MEM/WB stage and the register-file write port.

Parameters:
- ENTRIES, 16, number of ROB slots; power of two.
- IDX_WIDTH, 4, log2(ENTRIES); width of every ROB index.
- XLEN, 32, data width of result values.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_flush  input  1  discard all entries (exception or mispredict).
- in_alloc_valid  input  1  issue requests a new entry this cycle.
- in_alloc_rd  input  5  destination register of the allocating instruction.
- in_alloc_write_enable  input  1  instruction writes the register file.
- out_alloc_ready  output  1  an entry is free; allocation is accepted this cycle.
- out_alloc_idx  output  IDX_WIDTH  index granted to the allocating instruction (the current tail).
- in_complete  input  1  writeback completion strobe (from MEM/WB out_complete).
- in_complete_idx  input  IDX_WIDTH  entry being completed (from MEM/WB out_complete_idx).
- in_complete_value  input  XLEN  final result (ALU or memory value already selected).
- out_commit_valid  output  1  head entry retires this cycle.
- out_commit_rd  output  5  rd of the retiring entry.
- out_commit_value  output  XLEN  value of the retiring entry.
- out_commit_write_enable  output  1  register-file write enable; equals out_commit_valid AND the entry's write_enable.
- out_full  output  1  count == ENTRIES.
- out_empty  output  1  count == 0.

Behaviour:
- State:
  - Per-entry fields: valid, complete, rd, write_enable, value.
  - Pointers: head and tail, each IDX_WIDTH wide; both wrap naturally modulo ENTRIES.
  - count is IDX_WIDTH+1 bits wide.
- Reset (synchronous, active-high):
  - Clear every field of every entry; head = tail = count = 0.
  - Outputs after reset: out_alloc_ready=1, out_alloc_idx=0, out_commit_valid=0, out_commit_rd=0, out_commit_value=0, out_commit_write_enable=0, out_full=0, out_empty=1.
  - Reset mid-operation discards all in-flight entries; there is no partial commit.
- Combinational outputs (all derived from registered state only; no input-to-output bypass):
  - out_alloc_ready = !out_full.
  - out_alloc_idx = tail.
  - out_commit_valid = entry[head].valid && entry[head].complete.
  - Commit data fields come from entry[head]. When out_commit_valid=0 they are driven to 0.
- Allocate (in_alloc_valid && out_alloc_ready):
  - entry[tail] gets valid=1, complete=0, rd and write_enable from the inputs, value=0.
  - tail increments.
  - in_alloc_valid while full is ignored; issue must stall.
- Complete (in_complete):
  - If entry[in_complete_idx].valid: set complete=1 and value=in_complete_value.
  - Completion to an invalid entry is ignored and does not disturb state.
  - Repeated completion of the same entry overwrites the value.
- Commit (out_commit_valid):
  - At posedge, clear entry[head].valid and entry[head].complete; head increments.
  - Exactly one retirement per cycle maximum.
- Latency:
  - Completion at cycle N gives the earliest commit of that entry at cycle N+1.
  - Allocation at cycle N gives the earliest completion accepted at cycle N+1.
- Count update: count += alloc_fire − commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Full boundary: when full, alloc is blocked even if a commit fires the same cycle (ready is based on the pre-edge count). The slot becomes free next cycle.
- Empty boundary: out_commit_valid=0 because the head entry is invalid.
- Same-cycle completion and allocation on the same index cannot occur legally; if it does, allocation wins.
- Flush:
  - Clears valid and complete of all entries; head = tail = count = 0.
  - Has priority over alloc, complete and commit arriving in the same cycle.
  - A commit shown in the flush cycle is suppressed: the state update is dropped, although out_commit_valid is still visible combinationally. The register-file side must gate its write with in_flush.

Decomposition:
- Shared package rob_pkg:
  - Constants ROB_ENTRIES=16, ROB_IDX_WIDTH=4.
  - Typedef rob_idx_t.
  - Typedef rob_entry_t (valid, complete, rd[4:0], write_enable, value[XLEN-1:0]).
- The MEM/WB register and issue logic import rob_idx_t from rob_pkg.
- No sub-module: the entry array and pointer logic stay in one module.

Test Plan:
- Reset then idle → out_empty=1, out_alloc_ready=1, out_alloc_idx=0, out_commit_valid=0.
- Allocate 3 entries (rd=1,2,3, we=1); complete idx 0 with 0x11 → next cycle out_commit_valid=1, out_commit_rd=1, out_commit_value=0x11; head advances to 1.
- Out-of-order completion: complete idx 2 (0x33), then idx 1 (0x22) → commits in order rd=2/0x22, then rd=3/0x33, on consecutive cycles.
- Fill 16 entries → out_full=1, out_alloc_ready=0. Alloc while full with a simultaneous commit → no allocation that cycle, alloc accepted next cycle at idx 0. Wrap verified: tail=1, count=16.
- Completion strobe to an unallocated idx 5 (0xDEAD) → no state change. Entry with we=0 commits with out_commit_write_enable=0, out_commit_valid=1.
- 5 entries in flight, 2 complete; assert in_flush together with alloc and complete → next cycle out_empty=1, out_alloc_idx=0, no commits; the same sequence with reset instead gives identical results.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types: index width, entry layout and default sizing.
// The MEM/WB register and issue logic import rob_idx_t from here.
package rob_pkg;

  localparam int ROB_ENTRIES   = 16;
  localparam int ROB_IDX_WIDTH = 4;
  localparam int ROB_XLEN      = 32;

  typedef logic [ROB_IDX_WIDTH-1:0] rob_idx_t;

  typedef struct packed {
    logic                valid;
    logic                complete;
    logic [4:0]          rd;
    logic                write_enable;
    logic [ROB_XLEN-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback and commit signals of the reorder buffer.
// master = pipeline side, slave = ROB side.
interface reorder_buffer_if #(
  parameter int IDX_WIDTH = 4,
  parameter int XLEN      = 32
);

  logic                 in_flush;
  logic                 in_alloc_valid;
  logic [4:0]           in_alloc_rd;
  logic                 in_alloc_write_enable;
  logic                 out_alloc_ready;
  logic [IDX_WIDTH-1:0] out_alloc_idx;
  logic                 in_complete;
  logic [IDX_WIDTH-1:0] in_complete_idx;
  logic [XLEN-1:0]      in_complete_value;
  logic                 out_commit_valid;
  logic [4:0]           out_commit_rd;
  logic [XLEN-1:0]      out_commit_value;
  logic                 out_commit_write_enable;
  logic                 out_full;
  logic                 out_empty;

  modport master (
    output in_flush, in_alloc_valid, in_alloc_rd, in_alloc_write_enable,
    output in_complete, in_complete_idx, in_complete_value,
    input  out_alloc_ready, out_alloc_idx,
    input  out_commit_valid, out_commit_rd, out_commit_value, out_commit_write_enable,
    input  out_full, out_empty
  );

  modport slave (
    input  in_flush, in_alloc_valid, in_alloc_rd, in_alloc_write_enable,
    input  in_complete, in_complete_idx, in_complete_value,
    output out_alloc_ready, out_alloc_idx,
    output out_commit_valid, out_commit_rd, out_commit_value, out_commit_write_enable,
    output out_full, out_empty
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocate at tail, complete out of order,
// retire at most one completed head entry per cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ENTRIES   = ROB_ENTRIES,
  parameter int IDX_WIDTH = ROB_IDX_WIDTH,
  parameter int XLEN      = ROB_XLEN
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rob
);

  localparam logic [IDX_WIDTH:0]   FULL_COUNT = (IDX_WIDTH+1)'(ENTRIES);
  localparam logic [IDX_WIDTH:0]   CNT_ONE    = (IDX_WIDTH+1)'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE    = IDX_WIDTH'(1);

  rob_entry_t           entry_q [ENTRIES];
  logic [IDX_WIDTH-1:0] head;
  logic [IDX_WIDTH-1:0] tail;
  logic [IDX_WIDTH:0]   count;

  logic full;
  logic commit_fire;
  logic alloc_fire;

  assign full        = (count == FULL_COUNT);
  assign commit_fire = entry_q[head].valid && entry_q[head].complete;
  // Ready uses the pre-edge count, so a full ROB stays closed even while retiring.
  assign alloc_fire  = rob.in_alloc_valid && !full;

  assign rob.out_full                = full;
  assign rob.out_empty               = (count == '0);
  assign rob.out_alloc_ready         = !full;
  assign rob.out_alloc_idx           = tail;
  assign rob.out_commit_valid        = commit_fire;
  assign rob.out_commit_rd           = commit_fire ? entry_q[head].rd : 5'd0;
  assign rob.out_commit_value        = commit_fire ? entry_q[head].value : '0;
  assign rob.out_commit_write_enable = commit_fire && entry_q[head].write_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rob.in_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i].valid    <= 1'b0;
        entry_q[i].complete <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (rob.in_complete && entry_q[rob.in_complete_idx].valid) begin
        entry_q[rob.in_complete_idx].complete <= 1'b1;
        entry_q[rob.in_complete_idx].value    <= rob.in_complete_value;
      end
      if (commit_fire) begin
        entry_q[head].valid    <= 1'b0;
        entry_q[head].complete <= 1'b0;
        head                   <= head + IDX_ONE;
      end
      // Last write wins: an illegal same-index completion loses to allocation.
      if (alloc_fire) begin
        entry_q[tail] <= '{valid:        1'b1,
                           complete:     1'b0,
                           rd:           rob.in_alloc_rd,
                           write_enable: rob.in_alloc_write_enable,
                           value:        '0};
        tail <= tail + IDX_ONE;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expected retirements are queued when
// completions are driven and compared as the head retires.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.IDX_WIDTH(4), .XLEN(32)) rif ();

  reorder_buffer #(.ENTRIES(16), .IDX_WIDTH(4), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif.slave)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pop and compare any retirement visible before the edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (rif.out_commit_valid === 1'b1 && !rif.in_flush && !reset) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("commit_rd", 64'(rif.out_commit_rd), 64'(e.rd));
        check("commit_value", 64'(rif.out_commit_value), 64'(e.value));
        check("commit_we", 64'(rif.out_commit_write_enable), 64'(e.we));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rif.in_flush              = 1'b0;
    rif.in_alloc_valid        = 1'b0;
    rif.in_alloc_rd           = 5'd0;
    rif.in_alloc_write_enable = 1'b0;
    rif.in_complete           = 1'b0;
    rif.in_complete_idx       = 4'd0;
    rif.in_complete_value     = 32'd0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic we);
    rif.in_alloc_valid        = 1'b1;
    rif.in_alloc_rd           = rd;
    rif.in_alloc_write_enable = we;
    tick();
    rif.in_alloc_valid        = 1'b0;
  endtask

  task automatic complete(input logic [3:0] idx, input logic [31:0] val);
    rif.in_complete       = 1'b1;
    rif.in_complete_idx   = idx;
    rif.in_complete_value = val;
    tick();
    rif.in_complete       = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_empty"}, 64'(rif.out_empty), 64'd1);
    check({tag, "_full"}, 64'(rif.out_full), 64'd0);
    check({tag, "_ready"}, 64'(rif.out_alloc_ready), 64'd1);
    check({tag, "_alloc_idx"}, 64'(rif.out_alloc_idx), 64'd0);
    check({tag, "_commit_valid"}, 64'(rif.out_commit_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_cleared("rst");
    check("rst_commit_rd", 64'(rif.out_commit_rd), 64'd0);
    check("rst_commit_value", 64'(rif.out_commit_value), 64'd0);
    check("rst_commit_we", 64'(rif.out_commit_write_enable), 64'd0);

    // Three allocations, complete the head
    for (int i = 0; i < 3; i++) begin
      check("alloc_idx_seq", 64'(rif.out_alloc_idx), 64'(i));
      alloc(5'(i + 1), 1'b1);
    end
    sb.push_back('{rd: 5'd1, value: 32'h11, we: 1'b1});
    complete(4'd0, 32'h11);
    check("c0_valid", 64'(rif.out_commit_valid), 64'd1);
    check("c0_rd", 64'(rif.out_commit_rd), 64'd1);
    check("c0_value", 64'(rif.out_commit_value), 64'h11);
    tick();
    check("after_c0_valid", 64'(rif.out_commit_valid), 64'd0);
    check("after_c0_tail", 64'(rif.out_alloc_idx), 64'd3);

    // Out-of-order completion retires in program order
    complete(4'd2, 32'h33);
    check("ooo_blocked", 64'(rif.out_commit_valid), 64'd0);
    sb.push_back('{rd: 5'd2, value: 32'h22, we: 1'b1});
    sb.push_back('{rd: 5'd3, value: 32'h33, we: 1'b1});
    complete(4'd1, 32'h22);
    check("ooo_first_rd", 64'(rif.out_commit_rd), 64'd2);
    tick();
    check("ooo_second_valid", 64'(rif.out_commit_valid), 64'd1);
    check("ooo_second_rd", 64'(rif.out_commit_rd), 64'd3);
    tick();
    check("ooo_empty", 64'(rif.out_empty), 64'd1);

    // Fill, blocked alloc while full with a simultaneous commit, then wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) alloc(5'(i + 4), 1'b1);
    check("fill_full", 64'(rif.out_full), 64'd1);
    check("fill_ready", 64'(rif.out_alloc_ready), 64'd0);
    check("fill_tail_wrap", 64'(rif.out_alloc_idx), 64'd0);
    sb.push_back('{rd: 5'd4, value: 32'hA0, we: 1'b1});
    complete(4'd0, 32'hA0);
    rif.in_alloc_valid        = 1'b1;
    rif.in_alloc_rd           = 5'd7;
    rif.in_alloc_write_enable = 1'b0;
    check("full_commit_valid", 64'(rif.out_commit_valid), 64'd1);
    check("full_ready_blocked", 64'(rif.out_alloc_ready), 64'd0);
    tick();
    check("freed_full", 64'(rif.out_full), 64'd0);
    check("freed_alloc_idx", 64'(rif.out_alloc_idx), 64'd0);
    tick();
    rif.in_alloc_valid = 1'b0;
    check("wrap_tail", 64'(rif.out_alloc_idx), 64'd1);
    check("wrap_full", 64'(rif.out_full), 64'd1);

    // Drain in order, last entry has write_enable=0
    for (int i = 1; i < 16; i++) begin
      sb.push_back('{rd: 5'(i + 4), value: 32'h100 + 32'(i), we: 1'b1});
      complete(4'(i), 32'h100 + 32'(i));
    end
    sb.push_back('{rd: 5'd7, value: 32'h200, we: 1'b0});
    complete(4'd0, 32'h200);
    for (int k = 0; k < 40 && rif.out_empty !== 1'b1; k++) tick();
    check("drain_empty", 64'(rif.out_empty), 64'd1);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Completion to an unallocated entry is ignored
    complete(4'd5, 32'hDEAD);
    check("stray_empty", 64'(rif.out_empty), 64'd1);
    check("stray_commit_valid", 64'(rif.out_commit_valid), 64'd0);
    check("stray_tail", 64'(rif.out_alloc_idx), 64'd1);
    alloc(5'd9, 1'b0);
    sb.push_back('{rd: 5'd9, value: 32'h55, we: 1'b0});
    complete(4'd1, 32'h55);
    check("nowe_valid", 64'(rif.out_commit_valid), 64'd1);
    check("nowe_we", 64'(rif.out_commit_write_enable), 64'd0);
    tick();

    // Flush with five in flight, colliding with alloc and complete
    for (int i = 0; i < 5; i++) alloc(5'(i + 10), 1'b1);
    complete(4'd3, 32'h3333);
    complete(4'd4, 32'h4444);
    rif.in_flush        = 1'b1;
    rif.in_alloc_valid  = 1'b1;
    rif.in_alloc_rd     = 5'd20;
    rif.in_complete     = 1'b1;
    rif.in_complete_idx = 4'd2;
    tick();
    idle_inputs();
    check_cleared("flush");
    tick();
    tick();
    check("flush_no_commit", 64'(rif.out_commit_valid), 64'd0);

    // Same sequence with reset in place of flush
    for (int i = 0; i < 5; i++) alloc(5'(i + 10), 1'b1);
    complete(4'd1, 32'h1111);
    complete(4'd2, 32'h2222);
    reset               = 1'b1;
    rif.in_alloc_valid  = 1'b1;
    rif.in_alloc_rd     = 5'd20;
    rif.in_complete     = 1'b1;
    rif.in_complete_idx = 4'd0;
    tick();
    reset = 1'b0;
    idle_inputs();
    check_cleared("rst2");
    tick();
    tick();
    check("rst2_no_commit", 64'(rif.out_commit_valid), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
